// File: rtl/dense_layer_sequencer.sv
// Walks a descriptor table in SDRAM and drives the dense accelerator's register port
// once per layer: fetch five words, program five registers, start, poll until idle.
module dense_layer_sequencer #(
    parameter int DESC_STRIDE = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       slave_address,
    input  logic             slave_read,
    output logic [31:0]      slave_readdata,
    input  logic             slave_write,
    input  logic [31:0]      slave_writedata,
    output logic             slave_waitrequest,
    output logic [31:0]      desc_address,
    output logic             desc_read,
    input  logic [31:0]      desc_readdata,
    input  logic             desc_waitrequest,
    output logic [2:0]       acc_address,
    output logic             acc_read,
    output logic             acc_write,
    output logic [31:0]      acc_writedata,
    input  logic [31:0]      acc_readdata,
    input  logic             acc_waitrequest,
    output logic             irq
);
    // Handshake: a master transfer completes on the rising edge where its strobe is high
    // and the matching waitrequest is low; strobe, address and data hold until then.

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_PROG, S_START, S_POLL, S_NEXT
    } state_t;

    localparam logic [31:0] STRIDE_BYTES = 32'(DESC_STRIDE * 4);

    state_t           state;
    logic [31:0]      desc_base;
    logic [CNT_W-1:0] num_layers;
    logic [CNT_W-1:0] layer_idx;
    logic             irq_en;
    logic             done;
    logic [2:0]       w_idx;
    logic [31:0]      words [0:4];

    logic             busy;
    logic             start_req;
    logic [CNT_W-1:0] next_idx;
    logic             unused_ok;

    assign busy              = (state != S_IDLE);
    assign start_req         = slave_write && (slave_address == 2'd0) && slave_writedata[0];
    assign next_idx          = layer_idx + CNT_W'(1);
    assign slave_waitrequest = 1'b0;
    assign irq               = done & irq_en;
    assign unused_ok         = ^{slave_read, acc_readdata};

    always_comb begin
        slave_readdata = '0;
        case (slave_address)
            2'd0: slave_readdata[1] = irq_en;
            2'd1: slave_readdata = desc_base;
            2'd2: slave_readdata[CNT_W-1:0] = num_layers;
            default: begin
                slave_readdata[16 +: CNT_W] = layer_idx;
                slave_readdata[1]           = done;
                slave_readdata[0]           = busy;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            desc_base     <= '0;
            num_layers    <= '0;
            layer_idx     <= '0;
            irq_en        <= 1'b0;
            done          <= 1'b0;
            w_idx         <= '0;
            desc_address  <= '0;
            desc_read     <= 1'b0;
            acc_address   <= '0;
            acc_read      <= 1'b0;
            acc_write     <= 1'b0;
            acc_writedata <= '0;
            for (int i = 0; i < 5; i++) words[i] <= '0;
        end else begin
            if (slave_write) begin
                case (slave_address)
                    2'd0: irq_en <= slave_writedata[1];
                    2'd1: if (!busy) desc_base <= slave_writedata;
                    2'd2: if (!busy) num_layers <= slave_writedata[CNT_W-1:0];
                    default: ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        layer_idx <= '0;
                        w_idx     <= '0;
                        done      <= (num_layers == '0);
                        if (num_layers != '0) begin
                            state        <= S_FETCH;
                            desc_read    <= 1'b1;
                            desc_address <= desc_base;
                        end
                    end
                end
                S_FETCH: begin
                    if (!desc_waitrequest) begin
                        words[w_idx] <= desc_readdata;
                        if (w_idx == 3'd4) begin
                            state         <= S_PROG;
                            desc_read     <= 1'b0;
                            desc_address  <= '0;
                            acc_write     <= 1'b1;
                            acc_address   <= 3'd1;
                            acc_writedata <= words[0];
                        end else begin
                            w_idx        <= w_idx + 3'd1;
                            desc_address <= desc_address + 32'd4;
                        end
                    end
                end
                S_PROG: begin
                    // Register k carries descriptor word k-1; words[acc_address] is the next one.
                    if (!acc_waitrequest) begin
                        if (acc_address == 3'd5) begin
                            state         <= S_START;
                            acc_address   <= 3'd0;
                            acc_writedata <= 32'd1;
                        end else begin
                            acc_address   <= acc_address + 3'd1;
                            acc_writedata <= words[acc_address];
                        end
                    end
                end
                S_START: begin
                    if (!acc_waitrequest) begin
                        state         <= S_POLL;
                        acc_write     <= 1'b0;
                        acc_writedata <= '0;
                        acc_read      <= 1'b1;
                        acc_address   <= 3'd5;
                    end
                end
                S_POLL: begin
                    if (!acc_waitrequest) begin
                        state       <= S_NEXT;
                        acc_read    <= 1'b0;
                        acc_address <= '0;
                    end
                end
                S_NEXT: begin
                    layer_idx <= next_idx;
                    if (next_idx == num_layers) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        state        <= S_FETCH;
                        w_idx        <= '0;
                        desc_read    <= 1'b1;
                        desc_address <= desc_base + 32'(next_idx) * STRIDE_BYTES;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Randomized bench for dense_layer_sequencer: transaction-level expected queue built from
// the descriptor-table rules, checked against every accepted master transfer.
module tb_dense_layer_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  slave_address = 2'd3;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic        slave_waitrequest;
    logic [31:0] desc_address;
    logic        desc_read;
    logic [31:0] desc_readdata = '0;
    logic        desc_waitrequest = 1'b0;
    logic [2:0]  acc_address;
    logic        acc_read;
    logic        acc_write;
    logic [31:0] acc_writedata;
    logic [31:0] acc_readdata = '0;
    logic        acc_waitrequest = 1'b0;
    logic        irq;

    dense_layer_sequencer dut (
        .clk(clk), .reset(reset),
        .slave_address(slave_address), .slave_read(slave_read),
        .slave_readdata(slave_readdata), .slave_write(slave_write),
        .slave_writedata(slave_writedata), .slave_waitrequest(slave_waitrequest),
        .desc_address(desc_address), .desc_read(desc_read),
        .desc_readdata(desc_readdata), .desc_waitrequest(desc_waitrequest),
        .acc_address(acc_address), .acc_read(acc_read), .acc_write(acc_write),
        .acc_writedata(acc_writedata), .acc_readdata(acc_readdata),
        .acc_waitrequest(acc_waitrequest), .irq(irq)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [65:0] exp_q[$];      // {kind, address, data}; kind 0 desc read, 1 acc write, 2 acc read
    logic [31:0] obs_desc[$];
    int          stall_pct = 0;
    int          poll_len = 40;
    int          poll_cnt = 0;
    bit          prev_stall = 0;
    bit          prev_start = 0;
    logic [69:0] prev_snap = '0;
    logic [7:0]  model_layer = '0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ {a[15:0], a[31:16]};
    endfunction

    // Expected transfers for a run of n layers from a table at base.
    task automatic push_run(input logic [31:0] base, input int n);
        logic [31:0] a;
        model_layer = '0;
        for (int l = 0; l < n; l++) begin
            for (int w = 0; w < 5; w++) begin
                a = base + 32'((l * 8 + w) * 4);
                exp_q.push_back({2'd0, a, 32'd0});
            end
            for (int k = 1; k <= 5; k++) begin
                a = base + 32'((l * 8 + k - 1) * 4);
                exp_q.push_back({2'd1, 29'd0, 3'(k), mem_word(a)});
            end
            exp_q.push_back({2'd1, 32'd0, 32'd1});
            exp_q.push_back({2'd2, 29'd0, 3'd5, 32'd0});
        end
    endtask

    // Memory and accelerator responder plus per-cycle protocol checks.
    task automatic bus_cycle();
        logic [69:0] snap;
        logic [65:0] obs;
        bit          acc;
        int          nstrobe;
        snap = {desc_read, desc_address, acc_read, acc_write, acc_address, acc_writedata};
        if (!reset) begin
            prev_stall = 0;
            prev_start = 0;
            poll_cnt   = 0;
            return;
        end
        nstrobe = int'(desc_read) + int'(acc_read) + int'(acc_write);
        check("strobes_exclusive", 96'(nstrobe > 1), 96'd0);
        if (prev_stall) check("held_while_stalled", 96'(snap), 96'(prev_snap));
        if (prev_start) check("poll_follows_start", 96'(acc_read), 96'd1);
        prev_start = 0;
        if (nstrobe != 0 && exp_q.size() == 0)
            check("unexpected_strobe", 96'({desc_read, acc_read, acc_write}), 96'd0);

        desc_waitrequest = ($urandom_range(0, 99) < stall_pct);
        desc_readdata    = mem_word(desc_address);
        if (acc_read) acc_waitrequest = (poll_cnt != 0);
        else          acc_waitrequest = ($urandom_range(0, 99) < stall_pct);
        acc_readdata = $urandom;
        if (poll_cnt > 0) poll_cnt--;

        acc = 1'b1;
        obs = '0;
        if (desc_read && !desc_waitrequest) begin
            obs = {2'd0, desc_address, 32'd0};
            obs_desc.push_back(desc_address);
        end else if (acc_write && !acc_waitrequest) begin
            obs = {2'd1, 29'd0, acc_address, acc_writedata};
            if (acc_address == 3'd0) begin
                poll_cnt   = poll_len;
                prev_start = 1;
                if (slave_address == 2'd3 && !slave_write)
                    check("status_during_run", 96'(slave_readdata),
                          96'({8'h00, model_layer, 16'h0001}));
            end
        end else if (acc_read && !acc_waitrequest) begin
            obs = {2'd2, 29'd0, acc_address, 32'd0};
            model_layer++;
        end else begin
            acc = 1'b0;
        end
        if (acc && exp_q.size() > 0) check("transfer", 96'(obs), 96'(exp_q.pop_front()));

        prev_stall = (desc_read && desc_waitrequest) ||
                     ((acc_read || acc_write) && acc_waitrequest);
        prev_snap  = snap;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            bus_cycle();
        end
    end

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(negedge clk);
        slave_write   = 1'b0;
        slave_address = 2'd3;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        slave_address = a;
        #1;
        d = slave_readdata;
        slave_address = 2'd3;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (slave_readdata[1]) break;
        end
        check("done_within_budget", 96'(slave_readdata[1]), 96'd1);
        check("queue_drained", 96'(exp_q.size()), 96'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] base;
        bit          found;
        int          n;
        logic        ie;

        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 96'({desc_read, desc_address, acc_read, acc_write,
                                    acc_address, acc_writedata, irq, slave_waitrequest}), 96'd0);
        check("reset_status", 96'(slave_readdata), 96'd0);
        reset = 1'b1;

        // Zero layers: done on the next cycle, no master activity.
        cpu_write(2'd0, 32'h2);
        cpu_write(2'd2, 32'd0);
        cpu_write(2'd0, 32'h3);
        #1;
        check("zero_layer_status", 96'(slave_readdata), 96'h2);
        check("zero_layer_irq", 96'(irq), 96'd1);
        repeat (10) @(negedge clk);
        cpu_read(2'd0, rd);
        check("ctrl_readback", 96'(rd), 96'h2);

        // One layer, zero-wait memory, 40-cycle accelerator busy.
        stall_pct = 0;
        poll_len  = 40;
        cpu_write(2'd1, 32'h100);
        cpu_write(2'd2, 32'd1);
        push_run(32'h100, 1);
        check("model_first_addr", 96'(exp_q[0][63:32]), 96'h100);
        check("model_last_addr", 96'(exp_q[4][63:32]), 96'h110);
        check("model_start_write", 96'(exp_q[10]), 96'({2'd1, 32'd0, 32'd1}));
        cpu_write(2'd0, 32'h3);
        wait_done(500);
        check("one_layer_status", 96'(slave_readdata), 96'h0001_0002);
        check("one_layer_irq", 96'(irq), 96'd1);

        // Three layers with random stalls, descriptor stride check.
        stall_pct = 40;
        poll_len  = $urandom_range(1, 15);
        base = $urandom;
        base = {base[31:2], 2'b00};
        obs_desc.delete();
        cpu_write(2'd1, base);
        cpu_write(2'd2, 32'd3);
        push_run(base, 3);
        cpu_write(2'd0, 32'h1);
        check("irq_low_while_busy", 96'(irq), 96'd0);
        wait_done(3000);
        check("three_layer_status", 96'(slave_readdata), 96'h0003_0002);
        check("desc_count", 96'(obs_desc.size()), 96'd15);
        if (obs_desc.size() == 15) begin
            check("second_desc_base", 96'(obs_desc[5]), 96'(base + 32'h20));
            check("third_desc_base", 96'(obs_desc[10]), 96'(base + 32'h40));
        end
        check("irq_en_cleared", 96'(irq), 96'd0);

        // Writes and start while busy are ignored.
        base = 32'h0000_4000;
        cpu_write(2'd1, base);
        cpu_write(2'd2, 32'd2);
        push_run(base, 2);
        cpu_write(2'd0, 32'h1);
        repeat (15) @(negedge clk);
        cpu_write(2'd1, 32'h0BAD_0000);
        cpu_write(2'd2, 32'd7);
        cpu_write(2'd0, 32'h1);
        wait_done(3000);
        check("busy_write_status", 96'(slave_readdata), 96'h0002_0002);
        cpu_read(2'd1, rd);
        check("desc_base_kept", 96'(rd), 96'(base));
        cpu_read(2'd2, rd);
        check("num_layers_kept", 96'(rd), 96'd2);

        // Randomized runs.
        for (int r = 0; r < 4; r++) begin
            stall_pct = $urandom_range(0, 60);
            poll_len  = $urandom_range(0, 20);
            n  = $urandom_range(1, 4);
            ie = 1'($urandom_range(0, 1));
            base = $urandom;
            cpu_write(2'd0, {30'd0, ie, 1'b0});
            cpu_write(2'd1, base);
            cpu_write(2'd2, 32'(n));
            push_run(base, n);
            cpu_write(2'd0, {30'd0, ie, 1'b1});
            wait_done(4000);
            check("rand_status", 96'(slave_readdata), 96'({8'h00, 8'(n), 16'h0002}));
            check("rand_irq", 96'(irq), 96'(ie));
        end

        // Reset while polling the second layer.
        stall_pct = 20;
        poll_len  = 30;
        base = 32'h0002_0000;
        cpu_write(2'd0, 32'h2);
        cpu_write(2'd1, base);
        cpu_write(2'd2, 32'd3);
        push_run(base, 3);
        cpu_write(2'd0, 32'h3);
        found = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (acc_read && slave_readdata[23:16] == 8'd1) begin
                found = 1;
                break;
            end
        end
        check("reached_layer2_poll", 96'(found), 96'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", 96'({desc_read, desc_address, acc_read, acc_write,
                                          acc_address, acc_writedata, irq}), 96'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("status_after_reset", 96'(slave_readdata), 96'd0);
        cpu_read(2'd1, rd);
        check("desc_base_after_reset", 96'(rd), 96'd0);
        cpu_read(2'd0, rd);
        check("ctrl_after_reset", 96'(rd), 96'd0);
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
